// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-resource countdowns drive HOLD on RAW, WR, carry, MR and jump hazards.
// Optional stall statistics ports are enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int NREGS = 32,
    parameter int DEPTH = 3,
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          dec_valid,
    input  logic [6:0]    dec_type,
    input  logic [RW-1:0] dec_sela,
    input  logic [RW-1:0] dec_selc,
    input  logic          MR,
    input  logic          flush,
    output logic          HOLD,
    output logic          busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [4:0]    stall_cause
`endif
);

    logic [CW-1:0] rcnt_q [NREGS];
    logic [CW-1:0] rcnt_d [NREGS];
    logic [CW-1:0] wrcnt_q, wrcnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [CW-1:0] occ_q, occ_d;

    logic rdPending;
    logic hJump, hMr, hWr, hC, hR;
    logic issue;

    // Flush wins over a fresh write, which wins over the countdown.
    function automatic logic [CW-1:0] nextCnt(input logic [CW-1:0] cur,
                                              input logic          set,
                                              input logic          clr);
        logic [CW-1:0] nxt;
        nxt = '0;
        if (clr)
            nxt = '0;
        else if (set)
            nxt = CW'(DEPTH);
        else if (cur != '0)
            nxt = cur - CW'(1);
        return nxt;
    endfunction

    // Selects beyond NREGS never match a register index, so they are ignored.
    always_comb begin
        rdPending = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if ((dec_sela == RW'(i)) && (rcnt_q[i] != '0))
                rdPending = 1'b1;
        end
        hJump = dec_type[6] & (occ_q != '0);
        hMr   = MR & (wrcnt_q != '0);
        hWr   = dec_type[0] & (wrcnt_q != '0);
        hC    = dec_type[4] & (ccnt_q != '0);
        hR    = dec_type[2] & rdPending;
        HOLD  = dec_valid & (hJump | hMr | hWr | hC | hR);
        issue = dec_valid & ~HOLD;
        busy  = (occ_q != '0);
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rcnt_d[i] = nextCnt(rcnt_q[i],
                                issue & dec_type[3] & (dec_selc == RW'(i)),
                                flush);
        end
        wrcnt_d = nextCnt(wrcnt_q, issue & dec_type[1], flush);
        ccnt_d  = nextCnt(ccnt_q, issue & dec_type[5], flush);
        occ_d   = nextCnt(occ_q, issue, flush);
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            for (int i = 0; i < NREGS; i++)
                rcnt_q[i] <= '0;
            wrcnt_q <= '0;
            ccnt_q  <= '0;
            occ_q   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                rcnt_q[i] <= rcnt_d[i];
            wrcnt_q <= wrcnt_d;
            ccnt_q  <= ccnt_d;
            occ_q   <= occ_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [4:0]  stall_cause_q, stall_cause_d;

    // The stall counter saturates and survives flushes; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (HOLD && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        stall_cause_d = {hR, hC, hWr, hMr, hJump};
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            stall_cnt_q   <= '0;
            stall_cause_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            stall_cause_q <= stall_cause_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign stall_cause = stall_cause_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard using a timestamp-based reference model.
// Stats checks are compiled in when HAZARD_SCOREBOARD_STATS_EN is defined.
module tb_hazard_scoreboard;

    localparam int NREGS = 32;
    localparam int DEPTH = 3;

    logic       clk;
    logic       nreset;
    logic       dec_valid;
    logic [6:0] dec_type;
    logic [4:0] dec_sela;
    logic [4:0] dec_selc;
    logic       MR;
    logic       flush;
    logic       HOLD;
    logic       busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [4:0]  stall_cause;
`endif

    hazard_scoreboard #(.NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .nreset(nreset),
        .dec_valid(dec_valid),
        .dec_type(dec_type),
        .dec_sela(dec_sela),
        .dec_selc(dec_selc),
        .MR(MR),
        .flush(flush),
        .HOLD(HOLD),
        .busy(busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .stall_cause(stall_cause)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: each resource records the first cycle a dependent instruction may issue.
    longint cyc;
    longint regReady [NREGS];
    longint wrReady, cReady, occReady;
    logic   expHold, expBusy;
    logic   mR, mC, mWr, mMr, mJ;
    logic [15:0] expStallCnt;
    logic [4:0]  expCause;

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) regReady[i] = 0;
        wrReady = 0;
        cReady = 0;
        occReady = 0;
        expStallCnt = '0;
        expCause = '0;
    endtask

    task automatic modelEval();
        mR  = dec_type[2] && (cyc < regReady[dec_sela]);
        mC  = dec_type[4] && (cyc < cReady);
        mWr = dec_type[0] && (cyc < wrReady);
        mMr = MR && (cyc < wrReady);
        mJ  = dec_type[6] && (cyc < occReady);
        expHold = dec_valid && (mR || mC || mWr || mMr || mJ);
        expBusy = (cyc < occReady);
    endtask

    task automatic modelCommit();
        if (expHold && expStallCnt != 16'hFFFF) expStallCnt = expStallCnt + 16'd1;
        expCause = {mR, mC, mWr, mMr, mJ};
        if (flush) begin
            for (int i = 0; i < NREGS; i++) regReady[i] = 0;
            wrReady = 0;
            cReady = 0;
            occReady = 0;
        end else if (dec_valid && !expHold) begin
            if (dec_type[3]) regReady[dec_selc] = cyc + DEPTH + 1;
            if (dec_type[1]) wrReady = cyc + DEPTH + 1;
            if (dec_type[5]) cReady = cyc + DEPTH + 1;
            occReady = cyc + DEPTH + 1;
        end
        cyc++;
    endtask

    task automatic driveCycle(input logic v, input logic [6:0] t, input logic [4:0] a,
                              input logic [4:0] c, input logic m, input logic f);
        @(negedge clk);
        dec_valid = v;
        dec_type  = t;
        dec_sela  = a;
        dec_selc  = c;
        MR        = m;
        flush     = f;
        #1;
        modelEval();
    endtask

    task automatic advance();
        modelCommit();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        nreset = 1'b1;
        dec_valid = 1'b0;
        dec_type = '0;
        dec_sela = '0;
        dec_selc = '0;
        MR = 1'b0;
        flush = 1'b0;
        #2;
        nreset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        dec_valid = 1'b1;
        dec_type = 7'h7F;
        dec_sela = 5'd3;
        dec_selc = 5'd3;
        MR = 1'b1;
        flush = 1'b0;
        #3;
        total++;
        if (HOLD !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", HOLD); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
        total++;
        if (stall_cnt !== 16'd0 || stall_cause !== 5'd0) begin
            bad++; $display("FAIL reset_stats cnt=%0d cause=%b want 0/0", stall_cnt, stall_cause);
        end
`endif
        resetDut();
    endtask

    task automatic test_raw();
        int dutHold;
        resetDut();
        driveCycle(1'b1, 7'b0001000, 5'd0, 5'd5, 1'b0, 1'b0);
        total++;
        if (HOLD !== 1'b0) begin bad++; $display("FAIL raw_write_issue got=%b want=0", HOLD); end
        advance();
        dutHold = 0;
        for (int k = 0; k < 10; k++) begin
            driveCycle(1'b1, 7'b0000100, 5'd5, 5'd0, 1'b0, 1'b0);
            total++;
            if (HOLD !== expHold) begin bad++; $display("FAIL raw_hold k=%0d got=%b want=%b", k, HOLD, expHold); end
            if (HOLD === 1'b1) dutHold++;
`ifdef HAZARD_SCOREBOARD_STATS_EN
            if (k == 1) begin
                total++;
                if (stall_cause !== 5'b10000) begin
                    bad++; $display("FAIL raw_cause got=%b want=10000", stall_cause);
                end
            end
`endif
            if (!expHold) begin advance(); break; end
            advance();
        end
        total++;
        if (dutHold != DEPTH) begin bad++; $display("FAIL raw_hold_len got=%0d want=%0d", dutHold, DEPTH); end
`ifdef HAZARD_SCOREBOARD_STATS_EN
        total++;
        if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_stall_cnt got=%0d want=3", stall_cnt); end
`endif
        driveCycle(1'b1, 7'b0001000, 5'd0, 5'd5, 1'b0, 1'b0);
        advance();
        driveCycle(1'b1, 7'b0000100, 5'd6, 5'd0, 1'b0, 1'b0);
        total++;
        if (HOLD !== 1'b0) begin bad++; $display("FAIL raw_other_reg got=%b want=0", HOLD); end
        advance();
    endtask

    task automatic test_mem_read();
        int dutHold;
        resetDut();
        driveCycle(1'b1, 7'b0000010, 5'd0, 5'd0, 1'b0, 1'b0);
        advance();
        dutHold = 0;
        for (int k = 0; k < 10; k++) begin
            driveCycle(1'b1, 7'b0000000, 5'd1, 5'd2, 1'b1, 1'b0);
            total++;
            if (HOLD !== expHold) begin bad++; $display("FAIL mr_hold k=%0d got=%b want=%b", k, HOLD, expHold); end
            if (HOLD === 1'b1) dutHold++;
            if (!expHold) begin advance(); break; end
            advance();
        end
        total++;
        if (dutHold != DEPTH) begin bad++; $display("FAIL mr_hold_len got=%0d want=%0d", dutHold, DEPTH); end
        driveCycle(1'b1, 7'b0000010, 5'd0, 5'd0, 1'b0, 1'b0);
        advance();
        driveCycle(1'b1, 7'b0000000, 5'd1, 5'd2, 1'b0, 1'b0);
        total++;
        if (HOLD !== 1'b0) begin bad++; $display("FAIL mr_off got=%b want=0", HOLD); end
        advance();
    endtask

    task automatic test_jump();
        int dutHold;
        resetDut();
        for (int k = 0; k < 3; k++) begin
            driveCycle(1'b1, 7'b0000000, 5'(k), 5'(k), 1'b0, 1'b0);
            advance();
        end
        dutHold = 0;
        for (int k = 0; k < 10; k++) begin
            driveCycle(1'b1, 7'b1000000, 5'd0, 5'd0, 1'b0, 1'b0);
            total++;
            if (HOLD !== expHold || busy !== expBusy) begin
                bad++; $display("FAIL jump k=%0d hold=%b busy=%b want %b/%b", k, HOLD, busy, expHold, expBusy);
            end
            if (HOLD === 1'b1) dutHold++;
            if (!expHold) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL jump_busy_release got=%b want=0", busy); end
                advance();
                break;
            end
            advance();
        end
        total++;
        if (dutHold != DEPTH) begin bad++; $display("FAIL jump_hold_len got=%0d want=%0d", dutHold, DEPTH); end
    endtask

    task automatic test_flush();
        resetDut();
        driveCycle(1'b1, 7'b0001000, 5'd0, 5'd7, 1'b0, 1'b0);
        advance();
        driveCycle(1'b0, 7'b0000000, 5'd0, 5'd0, 1'b0, 1'b1);
        advance();
        driveCycle(1'b1, 7'b0000100, 5'd7, 5'd0, 1'b0, 1'b0);
        total++;
        if (HOLD !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_release hold=%b busy=%b want 0/0", HOLD, busy);
        end
        advance();
    endtask

    task automatic test_async_reset();
        resetDut();
        driveCycle(1'b1, 7'b0100000, 5'd0, 5'd0, 1'b0, 1'b0);
        advance();
        driveCycle(1'b1, 7'b0010000, 5'd0, 5'd0, 1'b0, 1'b0);
        advance();
        driveCycle(1'b1, 7'b0010000, 5'd0, 5'd0, 1'b0, 1'b0);
        total++;
        if (HOLD !== 1'b1) begin bad++; $display("FAIL carry_wait got=%b want=1", HOLD); end
        nreset = 1'b1;
        #1;
        total++;
        if (HOLD !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset hold=%b busy=%b want 0/0", HOLD, busy);
        end
        modelReset();
        nreset = 1'b0;
        #1;
        modelEval();
        advance();
    endtask

    task automatic test_random();
        logic [6:0] t;
        for (int k = 0; k < 400; k++) begin
            t = 7'($urandom);
            if ($urandom_range(0, 3) != 0) t[6] = 1'b0;
            driveCycle(($urandom_range(0, 7) != 0), t, 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 15) == 0));
            total++;
            if (HOLD !== expHold || busy !== expBusy) begin
                bad++; $display("FAIL random k=%0d hold=%b busy=%b want %b/%b", k, HOLD, busy, expHold, expBusy);
            end
`ifdef HAZARD_SCOREBOARD_STATS_EN
            total++;
            if (stall_cnt !== expStallCnt || stall_cause !== expCause) begin
                bad++; $display("FAIL random_stats k=%0d cnt=%0d cause=%b want %0d/%b",
                                k, stall_cnt, stall_cause, expStallCnt, expCause);
            end
`endif
            advance();
        end
    endtask

    initial begin
        cyc = 0;
        modelReset();
        test_reset();
        test_raw();
        test_mem_read();
        test_jump();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
